// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer pot scanner.
// Holds the pot enum, the ADC channel map, the 10-slot scan frame table,
// the register reset constants and the optional smoothing helper.
package eq_pkg;

    localparam int unsigned RES_W    = 12;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned N_POT    = 6;
    localparam int unsigned N_SLOT   = 10;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned SMOOTH_W = 14;

    typedef enum logic [2:0] {
        POT_LP  = 3'd0,
        POT_B1  = 3'd1,
        POT_B2  = 3'd2,
        POT_B3  = 3'd3,
        POT_HP  = 3'd4,
        POT_VOL = 3'd5
    } pot_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_UPD  = 2'd3
    } scan_state_e;

    // ADC channel wired to each pot, indexed by pot_e
    localparam logic [CH_W-1:0] CHNL_MAP [N_POT] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    // Volume is sampled every other slot so it tracks fastest
    localparam pot_e SLOT_TBL [N_SLOT] = '{POT_VOL, POT_LP, POT_VOL, POT_B1, POT_VOL,
                                           POT_B2,  POT_VOL, POT_B3, POT_VOL, POT_HP};

    localparam logic [RES_W-1:0] GAIN_UNITY = 12'h800;
    localparam logic [RES_W-1:0] VOL_MUTE   = 12'h000;

    // new = (3*old + res) >> 2, 14-bit intermediate so nothing overflows
    function automatic logic [RES_W-1:0] pot_smooth(input logic [RES_W-1:0] old_val,
                                                    input logic [RES_W-1:0] new_val);
        logic [SMOOTH_W-1:0] acc;
        acc = SMOOTH_W'(3) * SMOOTH_W'(old_val) + SMOOTH_W'(new_val);
        return RES_W'(acc >> 2);
    endfunction

endpackage

// File: rtl/pot_reg_file.sv
// Pot setting register file: six 12-bit settings, write decode, first-write
// mask and the all_valid flag.
// Optional feature macro: POT_SMOOTH_EN (IIR smoothing of every write after
// the first one for that pot).
// Ports: clk, rst (async, active-high); wr_en/wr_pot/wr_data write port;
//        lp/b1/b2/b3/hp_gain and volume setting outputs; all_valid.
module pot_reg_file
    import eq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  pot_e             wr_pot,
    input  logic [RES_W-1:0] wr_data,
    output logic [RES_W-1:0] lp_gain,
    output logic [RES_W-1:0] b1_gain,
    output logic [RES_W-1:0] b2_gain,
    output logic [RES_W-1:0] b3_gain,
    output logic [RES_W-1:0] hp_gain,
    output logic [RES_W-1:0] volume,
    output logic             all_valid
);

    logic [RES_W-1:0] regs_q [N_POT];
    logic [N_POT-1:0] mask_q;
    logic [N_POT-1:0] mask_nxt;
    logic [RES_W-1:0] wr_val;

    // Mask update and value to store
    always_comb begin
        mask_nxt = mask_q;
        if (wr_en) begin
            mask_nxt[wr_pot] = 1'b1;
        end
`ifdef POT_SMOOTH_EN
        // First write after reset loads directly so the filter does not start from unity
        wr_val = mask_q[wr_pot] ? pot_smooth(regs_q[wr_pot], wr_data) : wr_data;
`else
        wr_val = wr_data;
`endif
    end

    // Storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_POT); i++) begin
                regs_q[i] <= (i == int'(POT_VOL)) ? VOL_MUTE : GAIN_UNITY;
            end
            mask_q    <= '0;
            all_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[wr_pot] <= wr_val;
            end
            mask_q    <= mask_nxt;
            all_valid <= &mask_nxt;
        end
    end

    assign lp_gain = regs_q[POT_LP];
    assign b1_gain = regs_q[POT_B1];
    assign b2_gain = regs_q[POT_B2];
    assign b3_gain = regs_q[POT_B3];
    assign hp_gain = regs_q[POT_HP];
    assign volume  = regs_q[POT_VOL];

endmodule

// File: rtl/pot_scan_sched.sv
// Scan scheduler sharing one A2D SPI master among the six equalizer pots.
// Walks a fixed 10-slot frame (VOL every even slot), requests a conversion
// per slot after an idle gap, abandons a slot on timeout and stores results
// in pot_reg_file.
// Optional feature macro: POT_SMOOTH_EN (handled inside pot_reg_file).
// Ports: clk, rst (async, active-high), en; strt_cnv/chnnl request to the
//        SPI master, cnv_cmplt/res completion from it; gain and volume
//        outputs; all_valid, frame_done, timeout_err status.
module pot_scan_sched
    import eq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic [RES_W-1:0] lp_gain,
    output logic [RES_W-1:0] b1_gain,
    output logic [RES_W-1:0] b2_gain,
    output logic [RES_W-1:0] b3_gain,
    output logic [RES_W-1:0] hp_gain,
    output logic [RES_W-1:0] volume,
    output logic             all_valid,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

    scan_state_e       state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [SLOT_W-1:0] slot_q;
    logic              cap_vld;
    logic [RES_W-1:0]  cap_data;
    logic              gap_done;
    logic              to_done;
    logic              strt_nxt;
    logic              cap_nxt;
    logic              to_err_set;

    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign to_done  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state controls; completion beats timeout in WAIT
    always_comb begin
        state_nxt  = state;
        strt_nxt   = 1'b0;
        cap_nxt    = 1'b0;
        to_err_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (gap_done && en) begin
                    state_nxt = S_REQ;
                    strt_nxt  = 1'b1;
                end
            end
            S_REQ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnv_cmplt) begin
                    state_nxt = S_UPD;
                    cap_nxt   = 1'b1;
                end else if (to_done) begin
                    state_nxt  = S_UPD;
                    to_err_set = 1'b1;
                end
            end
            S_UPD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, slot pointer, capture and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt     <= '0;
            to_cnt      <= '0;
            slot_q      <= '0;
            cap_vld     <= 1'b0;
            cap_data    <= '0;
            strt_cnv    <= 1'b0;
            chnnl       <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Gap counter saturates at terminal count while en is low
            if (state == S_IDLE && state_nxt == S_IDLE) begin
                if (!gap_done) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end else begin
                gap_cnt <= '0;
            end

            if (state == S_WAIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            cap_vld <= cap_nxt;
            if (cap_nxt) begin
                cap_data <= res;
            end

            strt_cnv <= strt_nxt;
            if (strt_nxt) begin
                chnnl <= CHNL_MAP[SLOT_TBL[slot_q]];
            end

            frame_done <= (state == S_UPD) && (slot_q == SLOT_W'(N_SLOT - 1));
            if (state == S_UPD) begin
                slot_q <= (slot_q == SLOT_W'(N_SLOT - 1)) ? '0 : slot_q + SLOT_W'(1);
            end

            if (to_err_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // cap_vld is high only during UPD, so it doubles as the write strobe
    pot_reg_file u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cap_vld),
        .wr_pot    (SLOT_TBL[slot_q]),
        .wr_data   (cap_data),
        .lp_gain   (lp_gain),
        .b1_gain   (b1_gain),
        .b2_gain   (b2_gain),
        .b3_gain   (b3_gain),
        .hp_gain   (hp_gain),
        .volume    (volume),
        .all_valid (all_valid)
    );

endmodule

// File: tb/tb_pot_scan_sched.sv
// Scoreboard bench for pot_scan_sched: an ADC responder drives completions,
// a reference model predicts the snapshot seen at each conversion request,
// and a monitor compares it whenever the DUT raises strt_cnv.
module tb_pot_scan_sched;

    localparam int unsigned GAP = 16;
    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [11:0] lp_gain, b1_gain, b2_gain, b3_gain, hp_gain, volume;
    logic        all_valid, frame_done, timeout_err;

    pot_scan_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .cnv_cmplt   (cnv_cmplt),
        .res         (res),
        .lp_gain     (lp_gain),
        .b1_gain     (b1_gain),
        .b2_gain     (b2_gain),
        .b3_gain     (b3_gain),
        .hp_gain     (hp_gain),
        .volume      (volume),
        .all_valid   (all_valid),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       ch;
        logic [5:0][11:0] g;
        logic             av;
        logic             te;
        logic [31:0]      frames;
    } snap_t;

    snap_t exp_q[$];
    string sfail_q[$];
    snap_t fin_exp;
    bit    done = 1'b0;

    // Reference model; pot index order LP,B1,B2,B3,HP,VOL
    logic [11:0] m_reg [6];
    bit   [5:0]  m_mask;
    bit          m_te;
    int          slot_m;
    int          exp_frames = 0;
    int          chmap [6] = '{1, 0, 4, 2, 3, 7};
    string       nm [6] = '{"lp_gain", "b1_gain", "b2_gain", "b3_gain", "hp_gain", "volume"};

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;
    bit prev_strt = 1'b0;

    // Even slots read volume; odd slots walk LP,B1,B2,B3,HP
    function automatic int pot_of_slot(input int s);
        return (s % 2 == 0) ? 5 : (s - 1) / 2;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = (i == 5) ? 12'h000 : 12'h800;
        m_mask = '0;
        m_te   = 1'b0;
        slot_m = 0;
    endfunction

    function automatic void model_write(input int p, input logic [11:0] v);
`ifdef POT_SMOOTH_EN
        if (m_mask[p]) m_reg[p] = 12'((3 * int'(m_reg[p]) + int'(v)) / 4);
        else           m_reg[p] = v;
`else
        m_reg[p] = v;
`endif
        m_mask[p] = 1'b1;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.ch = 3'(chmap[pot_of_slot(slot_m)]);
        for (int i = 0; i < 6; i++) s.g[i] = m_reg[i];
        s.av     = &m_mask;
        s.te     = m_te;
        s.frames = 32'(exp_frames);
        return s;
    endfunction

    task automatic chk(input string what, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", what, act, req, $time);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (strt_cnv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One scan slot: respond after d cycles (d > TMO lands outside WAIT), or not at all
    task automatic run_slot(input bit respond, input logic [11:0] val, input int d, input bit drop_en);
        bit ok;
        int p;
        int dd;
        wait_req(ok);
        if (!ok) begin
            sfail_q.push_back("req_wait");
            return;
        end
        p  = pot_of_slot(slot_m);
        dd = d;
        if (drop_en) begin
            repeat (2) @(negedge clk);
            en = 1'b0;
            dd = d - 2;
        end
        if (respond) begin
            repeat (dd) @(negedge clk);
            cnv_cmplt = 1'b1;
            res       = val;
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (d <= int'(TMO)) model_write(p, val);
            else                m_te = 1'b1;
        end else begin
            m_te = 1'b1;
        end
        if (slot_m == 9) exp_frames++;
        slot_m = (slot_m + 1) % 10;
        if (en) exp_q.push_back(model_snap());
    endtask

    task automatic rand_slot();
        run_slot(1'b1, 12'($urandom), int'($urandom_range(1, TMO - 1)), 1'b0);
    endtask

    // Stimulus
    initial begin
        bit ok;
        rst = 1'b1; en = 1'b1; cnv_cmplt = 1'b0; res = '0;
        model_reset();
        exp_q.push_back(model_snap());
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frame 1: every channel reads 0xA5A
        for (int s = 0; s < 10; s++) run_slot(1'b1, 12'hA5A, int'($urandom_range(1, 20)), 1'b0);

        // Frame 2: completion on the exact expiry cycle, then reset mid-WAIT of slot 5
        run_slot(1'b1, 12'h123, int'(TMO), 1'b0);
        for (int s = 1; s < 5; s++) rand_slot();
        wait_req(ok);
        if (!ok) sfail_q.push_back("req_wait_rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        exp_q.push_back(model_snap());
        rst = 1'b0;

        // Timeout on slot 1, en dropped mid-WAIT on slot 4
        rand_slot();
        run_slot(1'b0, 12'h000, 0, 1'b0);
        rand_slot();
        rand_slot();
        run_slot(1'b1, 12'($urandom), int'($urandom_range(4, 30)), 1'b1);
        repeat (150) @(negedge clk);
        exp_q.push_back(model_snap());
        en = 1'b1;

        // Remaining slots, one late (ignored) completion on slot 7
        for (int s = 5; s < 10; s++) begin
            if (s == 7) run_slot(1'b1, 12'hFFF, int'(TMO) + 2, 1'b0);
            else        rand_slot();
        end
        for (int k = 0; k < 12; k++) rand_slot();
        run_slot(1'b1, 12'($urandom), int'($urandom_range(4, 30)), 1'b1);
        repeat (150) @(negedge clk);
        fin_exp = model_snap();
        done    = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        snap_t      e;
        logic [11:0] act [6];
        forever begin
            @(negedge clk);
            while (sfail_q.size() > 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: strt_cnv not seen within budget, expected a request", sfail_q.pop_front());
            end
            act[0] = lp_gain; act[1] = b1_gain; act[2] = b2_gain;
            act[3] = b3_gain; act[4] = hp_gain; act[5] = volume;
            if (frame_done && !rst) fd_cnt++;
            if (strt_cnv) begin
                chk("strt_cnv_one_cycle", int'(prev_strt), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strt_cnv", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("chnnl", int'(chnnl), int'(e.ch));
                    for (int i = 0; i < 6; i++) chk(nm[i], int'(act[i]), int'(e.g[i]));
                    chk("all_valid", int'(all_valid), int'(e.av));
                    chk("timeout_err", int'(timeout_err), int'(e.te));
                    chk("frame_done_count", fd_cnt, int'(e.frames));
                end
            end
            prev_strt = strt_cnv;
            if (done) begin
                for (int i = 0; i < 6; i++) chk({"final_", nm[i]}, int'(act[i]), int'(fin_exp.g[i]));
                chk("final_all_valid", int'(all_valid), int'(fin_exp.av));
                chk("final_timeout_err", int'(timeout_err), int'(fin_exp.te));
                chk("final_frame_done_count", fd_cnt, int'(fin_exp.frames));
                chk("pending_requests", exp_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pot_scan_sched.md
# pot_scan_sched

Scheduler that shares the single A2D SPI interface among the six equalizer slide pots (LP, B1, B2, B3, HP, VOLUME). It sequences conversions in a fixed priority frame, holds the latest 12-bit setting for each pot in registers, and presents them to the band filters and the volume scaler. It sits between the A2D SPI master and the equalizer datapath; the datapath reads gains only from this block.

## Interface
- GAP_CYCLES, 1024: idle clocks between the end of one conversion and the next request.
- TIMEOUT_CYCLES, 65535: maximum clocks to wait for `cnv_cmplt` before the slot is abandoned.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scanning enable. When low, the block finishes the current slot and then stays in IDLE.
- strt_cnv  out  1  one-cycle request to the SPI master.
- chnnl  out  3  ADC channel for the request. Stable from the `strt_cnv` cycle until the slot ends.
- cnv_cmplt  in  1  one-cycle completion strobe from the SPI master.
- res  in  12  conversion result. Valid in the `cnv_cmplt` cycle.
- lp_gain, b1_gain, b2_gain, b3_gain, hp_gain  out  12 each  band gains. Reset value 12'h800 (unity).
- volume  out  12  volume setting. Reset value 12'h000 (muted until the first read).
- all_valid  out  1  high once every pot has been updated at least once. Sticky until reset. Reset value 0.
- frame_done  out  1  one-cycle pulse when slot 9 completes. Reset value 0.
- timeout_err  out  1  sticky; set on any timeout. Reset value 0.

## Operation
- The frame has 10 slots, and VOLUME occupies every even slot:
  - slots 0-9 are VOL, LP, VOL, B1, VOL, B2, VOL, B3, VOL, HP;
  - the slot pointer wraps from 9 to 0.
- Channel map: LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7.
- FSM states are IDLE, REQ, WAIT and UPD.
  - IDLE: the gap counter counts up to GAP_CYCLES-1. At terminal count with `en`=1, go to REQ. The counter clears on leaving IDLE.
  - REQ: `strt_cnv`=1 for exactly one cycle, then go to WAIT. The timeout counter clears.
  - WAIT: on `cnv_cmplt`, capture `res` and go to UPD. If the timeout counter reaches TIMEOUT_CYCLES-1 first, set `timeout_err`, leave the target register unchanged and go to UPD without a write.
  - UPD: write the target register on a valid capture, advance the slot pointer, pulse `frame_done` if the slot was 9, then return to IDLE.
- If `cnv_cmplt` and timeout expiry occur in the same cycle, the completion wins: the data is written and no error is flagged.
- A `cnv_cmplt` arriving outside WAIT is ignored.
- An update mask bit per pot is set on its first successful write. `all_valid` is the AND of the six mask bits.
- Reset mid-conversion returns the block to IDLE at slot 0 with registers at their reset values. The SPI master is reset by the same `rst`.

## Timing
- `strt_cnv` rises on the first cycle after IDLE has completed GAP_CYCLES cycles.
- Gain registers update on the clock edge after the `cnv_cmplt` cycle (UPD) and are visible one cycle later.
- All outputs are registered; there are no combinational paths from input to output.
- Minimum slot length is GAP_CYCLES + 1 (REQ) + conversion time + 1 (UPD).

## Configuration
- POT_SMOOTH_EN defined: each write applies new = (3*old + res) >> 2, computed at 14 bits and truncated to 12.
  - The first write after reset loads `res` directly, as selected by the update mask bit.
- POT_SMOOTH_EN undefined: `res` is written directly.

## Structure
- `eq_pkg` holds:
  - the `pot_e` enum (LP, B1, B2, B3, HP, VOL);
  - the channel map constant array;
  - the 10-entry slot table;
  - the unity/mute reset constants.
- One sub-module, `pot_reg_file`: six registers, the write decode, the update mask and the optional smoothing.
- The FSM and counters live in the top module.

## Test plan
- Reset, then run one frame with the ADC model returning 12'hA5A on all channels, and observe the request sequence on `chnnl`:
  - `chnnl` follows 7,1,7,0,7,4,7,2,7,3;
  - after slot 9, all gains = 12'hA5A, `volume`=12'hA5A, `all_valid`=1, and `frame_done` has pulsed once.
- Hold `cnv_cmplt` low during slot 1:
  - `timeout_err`=1 after TIMEOUT_CYCLES;
  - `lp_gain` stays 12'h800;
  - slot 2 is requested with `chnnl`=7.
- Drive `cnv_cmplt` on the exact timeout-expiry cycle with `res`=12'h123: the target register gets 12'h123 and `timeout_err` stays 0.
- Assert `rst` during WAIT of slot 5: `b2_gain`=12'h800, `volume`=12'h000, `all_valid`=0; the next request has `chnnl`=7 (slot 0).
- With POT_SMOOTH_EN defined, B1 reads 12'h400 then 12'h800: `b1_gain` = 12'h400 then 12'h500.
- Drop `en` mid-WAIT: the slot completes and no further `strt_cnv` occurs. Re-raising `en` resumes at the next slot.
